llc_trace_writer: RTL

- Output-side counterpart to the trace-file input path.
- Captures the LLC's outgoing events (bus operations, snoop results, L2-to-L1 messages) in the order they occur and buffers them in a FIFO.
- Emits them as packed, sequence-numbered trace records over a valid/ready stream to the log/dump sink.
- On end of trace, drains, emits one summary record, then signals completion.

---
 rtl/llc_trace_writer_pkg.sv | 52 +++++
 rtl/llc_trace_writer_fifo.sv | 52 +++++
 rtl/llc_trace_writer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/llc_trace_writer_pkg.sv
// Shared types for the LLC trace writer: event encodings, record kinds, FSM states
// and the default-width trace record layout.
package llc_trace_writer_pkg;

    localparam int LLC_ADDR_BITS = 32;
    localparam int LLC_SEQ_BITS  = 16;
    localparam int LLC_DEPTH     = 8;

    typedef enum logic [2:0] {
        BUS_NONE       = 3'd0,
        BUS_READ       = 3'd1,
        BUS_WRITE      = 3'd2,
        BUS_INVALIDATE = 3'd3,
        BUS_RWIM       = 3'd4
    } bus_op_e;

    typedef enum logic [1:0] {
        SNP_HIT   = 2'd0,
        SNP_HITM  = 2'd1,
        SNP_NOHIT = 2'd2
    } snp_res_e;

    typedef enum logic [1:0] {
        MSG_GETLINE        = 2'd0,
        MSG_SENDLINE       = 2'd1,
        MSG_INVALIDATELINE = 2'd2,
        MSG_EVICTLINE      = 2'd3
    } msg_type_e;

    // Kind values double as the capture priority index (bus, snoop, msg).
    typedef enum logic [1:0] {
        KIND_BUS     = 2'd0,
        KIND_SNOOP   = 2'd1,
        KIND_MSG     = 2'd2,
        KIND_SUMMARY = 2'd3
    } rec_kind_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_SUMMARY = 2'd2,
        ST_DONE    = 2'd3
    } tw_state_e;

    typedef struct packed {
        logic [LLC_SEQ_BITS-1:0]  seq;
        rec_kind_e                kind;
        logic [2:0]               code;
        logic [LLC_ADDR_BITS-1:0] addr;
    } trace_rec_t;

endpackage

// File: rtl/llc_trace_writer_fifo.sv
// Show-ahead record FIFO accepting up to three pre-compacted pushes per cycle
// and one pop; reports free entries as seen before this cycle's pop.
module trace_rec_fifo #(
    parameter int W     = 53,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 push_cnt_i,
    input  logic [2:0][W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     free_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;

    assign empty_o = (count_q == '0);
    assign free_o  = CW'(DEPTH) - count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && !empty_o;

    // Pushes land in consecutive slots starting at the write pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < push_cnt_i) begin
                mem_q[wr_ptr_q + PW'(i)] <= push_data_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_cnt_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_ok);
            count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/llc_trace_writer.sv
// LLC outgoing-event trace writer: captures bus/snoop/message events into a FIFO
// as sequence-numbered records and closes the stream with one summary record.
module llc_trace_writer
    import llc_trace_writer_pkg::*;
#(
    parameter int ADDR_BITS = LLC_ADDR_BITS,
    parameter int DEPTH     = LLC_DEPTH,
    parameter int SEQ_BITS  = LLC_SEQ_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode_silent,
    input  logic                          bus_valid,
    input  logic [2:0]                    bus_op,
    input  logic [ADDR_BITS-1:0]          bus_addr,
    input  logic                          snp_valid,
    input  logic [1:0]                    snp_res,
    input  logic [ADDR_BITS-1:0]          snp_addr,
    input  logic                          msg_valid,
    input  logic [1:0]                    msg_type,
    input  logic [ADDR_BITS-1:0]          msg_addr,
    input  logic                          trace_end,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [SEQ_BITS+5+ADDR_BITS-1:0] rec_data,
    output logic [15:0]                   drop_cnt,
    output logic                          done
);

    localparam int REC_W = SEQ_BITS + 5 + ADDR_BITS;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [SEQ_BITS-1:0]  seq;
        rec_kind_e            kind;
        logic [2:0]           code;
        logic [ADDR_BITS-1:0] addr;
    } rec_t;

    tw_state_e            state_q, state_d;
    logic [SEQ_BITS-1:0]  seq_q, seq_d;
    logic [15:0]          drop_q, drop_d;
    logic [15:0]          total_q, total_d;
    logic [16:0]          drop_sum;

    logic [2:0]           ev_valid;
    logic [2:0]           ev_code [3];
    logic [ADDR_BITS-1:0] ev_addr [3];

    logic                 capture_en;
    logic [1:0]           push_cnt;
    logic [1:0]           drops;
    logic [2:0][REC_W-1:0] push_data;
    rec_t                 cap_rec;
    rec_t                 sum_rec;

    logic [REC_W-1:0]     fifo_head;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_free;
    logic                 pop;

    assign ev_valid   = {msg_valid, snp_valid, bus_valid};
    assign ev_code[0] = bus_op;
    assign ev_code[1] = {1'b0, snp_res};
    assign ev_code[2] = {1'b0, msg_type};
    assign ev_addr[0] = bus_addr;
    assign ev_addr[1] = snp_addr;
    assign ev_addr[2] = msg_addr;

    assign capture_en = (state_q == ST_RUN) && !mode_silent;

    // Compact accepted events into slots in priority order; whatever finds no
    // free entry (measured before this cycle's pop) is counted as dropped.
    always_comb begin
        push_cnt  = 2'd0;
        drops     = 2'd0;
        push_data = '0;
        cap_rec   = '0;
        if (capture_en) begin
            for (int i = 0; i < 3; i++) begin
                if (ev_valid[i]) begin
                    if (CW'(push_cnt) < fifo_free) begin
                        cap_rec.seq       = seq_q + SEQ_BITS'(push_cnt);
                        cap_rec.kind      = rec_kind_e'(2'(i));
                        cap_rec.code      = ev_code[i];
                        cap_rec.addr      = ev_addr[i];
                        push_data[push_cnt] = cap_rec;
                        push_cnt          = push_cnt + 2'd1;
                    end else begin
                        drops = drops + 2'd1;
                    end
                end
            end
        end
    end

    assign drop_sum = {1'b0, drop_q} + 17'(drops);
    assign seq_d    = seq_q + SEQ_BITS'(push_cnt);
    assign total_d  = total_q + 16'(push_cnt);
    assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_comb begin
        sum_rec      = '0;
        sum_rec.seq  = seq_q;
        sum_rec.kind = KIND_SUMMARY;
        sum_rec.code = 3'd0;
        sum_rec.addr = ADDR_BITS'({drop_q, total_q});
    end

    trace_rec_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .free_o      (fifo_free)
    );

    // Stream output follows the FIFO head until the summary takes over.
    always_comb begin
        state_d   = state_q;
        rec_valid = 1'b0;
        rec_data  = '0;
        pop       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                rec_valid = !fifo_empty;
                rec_data  = fifo_empty ? '0 : fifo_head;
                pop       = !fifo_empty && rec_ready;
                if (trace_end) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                rec_valid = !fifo_empty;
                rec_data  = fifo_empty ? '0 : fifo_head;
                pop       = !fifo_empty && rec_ready;
                if (fifo_empty) state_d = ST_SUMMARY;
            end
            ST_SUMMARY: begin
                rec_valid = 1'b1;
                rec_data  = sum_rec;
                if (rec_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            seq_q   <= '0;
            drop_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            total_q <= total_d;
        end
    end

    assign drop_cnt = drop_q;
    assign done     = (state_q == ST_DONE);

endmodule
